// File: rtl/multiply_pipe.sv
// multiply_pipe: pipelined integer multiplier (MUL/MULH/MULHSU/MULHU).
// The operands are registered as magnitudes with a product sign. Each stage
// then adds one XLEN/NUM_STAGES-bit slice of B, and a final output register
// negates the product and selects its low or high half.
// The output is a valid/ready slot: while it is full and not taken, the
// whole pipe holds. A branch flush kills every entry younger than the branch.
// Optional: define MULTIPLY_PIPE_PERF_CNT_EN to add the issue and flush counters.
module multiply_pipe #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned TAG_W      = 7,
    parameter int unsigned SQN_W      = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             IN_valid,
    input  logic [1:0]       IN_op,
    input  logic [XLEN-1:0]  IN_srcA,
    input  logic [XLEN-1:0]  IN_srcB,
    input  logic [TAG_W-1:0] IN_tagDst,
    input  logic [SQN_W-1:0] IN_sqN,
    input  logic             IN_branchValid,
    input  logic [SQN_W-1:0] IN_branchSqN,
    output logic             OUT_busy,
    output logic             OUT_valid,
    input  logic             OUT_ready,
    output logic [XLEN-1:0]  OUT_result,
    output logic [TAG_W-1:0] OUT_tagDst,
    output logic [SQN_W-1:0] OUT_sqN
`ifdef MULTIPLY_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]      OUT_perfIssued,
    output logic [31:0]      OUT_perfFlushed
`endif
);

    localparam int unsigned BITS = XLEN / NUM_STAGES;
    localparam int unsigned PW   = 2 * XLEN;
    localparam logic [PW-1:0] SLICE_MASK = (PW'(1) << BITS) - PW'(1);

    // Entry i has had slices 0..i-1 of B accumulated into acc.
    typedef struct packed {
        logic             v;
        logic             hi;
        logic             neg;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [PW-1:0]    acc;
        logic [TAG_W-1:0] tag;
        logic [SQN_W-1:0] sqn;
    } entry_t;

    entry_t           st_q [NUM_STAGES+1];
    entry_t           st_d [NUM_STAGES+1];
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [SQN_W-1:0] out_sqn_q, out_sqn_d;

    logic             stall, kill_in, accept;
    logic             a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             stage_hit [NUM_STAGES+1];
    logic             out_hit;
    logic [PW-1:0]    slice, pp, prod;

    // Younger-than-branch test, wrapping modulo 2^SQN_W.
    function automatic logic is_younger(input logic [SQN_W-1:0] sqn,
                                        input logic [SQN_W-1:0] br);
        logic [SQN_W-1:0] diff;
        diff = sqn - br;
        return !diff[SQN_W-1] && (diff != '0);
    endfunction

    assign stall      = out_valid_q && !OUT_ready;
    assign kill_in    = IN_branchValid && is_younger(IN_sqN, IN_branchSqN);
    assign accept     = IN_valid && en && !stall && !kill_in;
    assign OUT_busy   = stall;
    assign OUT_valid  = out_valid_q;
    assign OUT_result = out_result_q;
    assign OUT_tagDst = out_tag_q;
    assign OUT_sqN    = out_sqn_q;

    // Operand signedness and magnitudes; |INT_MIN| is kept as an unsigned value.
    always_comb begin
        a_neg = (IN_op != 2'd3) && IN_srcA[XLEN-1];
        b_neg = !IN_op[1] && IN_srcB[XLEN-1];
        a_mag = a_neg ? -IN_srcA : IN_srcA;
        b_mag = b_neg ? -IN_srcB : IN_srcB;
    end

    // Flush hits on every stored entry.
    always_comb begin
        for (int unsigned i = 0; i <= NUM_STAGES; i++) begin
            stage_hit[i] = IN_branchValid && st_q[i].v && is_younger(st_q[i].sqn, IN_branchSqN);
        end
        out_hit = IN_branchValid && out_valid_q && is_younger(out_sqn_q, IN_branchSqN);
    end

    // Next-state for the pipe. A stall freezes everything, but flush still clears valid bits.
    always_comb begin
        st_d         = st_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_sqn_d    = out_sqn_q;
        slice        = '0;
        pp           = '0;
        prod         = '0;
        if (stall) begin
            for (int unsigned i = 0; i <= NUM_STAGES; i++) begin
                if (stage_hit[i]) st_d[i].v = 1'b0;
            end
            if (out_hit) out_valid_d = 1'b0;
        end else begin
            prod = st_q[NUM_STAGES].neg ? -st_q[NUM_STAGES].acc : st_q[NUM_STAGES].acc;
            out_valid_d = st_q[NUM_STAGES].v && !stage_hit[NUM_STAGES];
            if (out_valid_d) begin
                out_result_d = st_q[NUM_STAGES].hi ? prod[PW-1:XLEN] : prod[XLEN-1:0];
                out_tag_d    = st_q[NUM_STAGES].tag;
                out_sqn_d    = st_q[NUM_STAGES].sqn;
            end
            for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
                slice = (PW'(st_q[k-1].b) >> (BITS * (k - 1))) & SLICE_MASK;
                pp    = (PW'(st_q[k-1].a) * slice) << (BITS * (k - 1));
                st_d[k]     = st_q[k-1];
                st_d[k].acc = st_q[k-1].acc + pp;
                st_d[k].v   = st_q[k-1].v && !stage_hit[k-1];
            end
            st_d[0].v   = accept;
            st_d[0].hi  = (IN_op != 2'd0);
            st_d[0].neg = a_neg ^ b_neg;
            st_d[0].a   = a_mag;
            st_d[0].b   = b_mag;
            st_d[0].acc = '0;
            st_d[0].tag = IN_tagDst;
            st_d[0].sqn = IN_sqN;
        end
    end

    // Pipe and output registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i <= NUM_STAGES; i++) st_q[i] <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_sqn_q    <= '0;
        end else begin
            st_q         <= st_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_sqn_q    <= out_sqn_d;
        end
    end

`ifdef MULTIPLY_PIPE_PERF_CNT_EN
    logic [31:0] flush_cnt;
    logic [31:0] perf_issued_q, perf_issued_d, perf_flushed_q, perf_flushed_d;

    // Number of stored entries killed this cycle (an incoming op that is killed was never issued).
    always_comb begin
        flush_cnt = '0;
        for (int unsigned i = 0; i <= NUM_STAGES; i++) begin
            flush_cnt = flush_cnt + 32'(stage_hit[i]);
        end
        flush_cnt      = flush_cnt + 32'(out_hit);
        perf_issued_d  = perf_issued_q + 32'(accept);
        perf_flushed_d = perf_flushed_q + flush_cnt;
    end

    // Free-running wrap-around counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issued_q  <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_issued_q  <= perf_issued_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign OUT_perfIssued  = perf_issued_q;
    assign OUT_perfFlushed = perf_flushed_q;
`endif

endmodule
